// File: rtl/hazard_ctrl_pkg.sv
// Shared state encodings and counter sizing helper for the hazard controller.
package hazard_ctrl_pkg;

  localparam int HC_STATE_WIDTH = 2;

  localparam logic [HC_STATE_WIDTH-1:0] HC_IDLE     = 2'd0;
  localparam logic [HC_STATE_WIDTH-1:0] HC_FLUSH    = 2'd1;
  localparam logic [HC_STATE_WIDTH-1:0] HC_MEM_WAIT = 2'd2;
  localparam logic [HC_STATE_WIDTH-1:0] HC_LOAD_USE = 2'd3;

  // Bits needed to hold max_val, never less than one.
  function automatic int hc_cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of hazard controller requests and stall/flush controls.
interface hazard_ctrl_if #(
  parameter int AWIDTH    = 5,
  parameter int CNT_WIDTH = 16
);
  import hazard_ctrl_pkg::*;

  logic                      hc_i_change_pc;
  logic                      hc_i_mem_req;
  logic                      hc_i_mem_ack;
  logic                      hc_i_ex_ce;
  logic                      hc_i_ex_is_load;
  logic [AWIDTH-1:0]         hc_i_ex_addr_rd;
  logic                      hc_i_id_ce;
  logic [AWIDTH-1:0]         hc_i_id_addr_rs1;
  logic [AWIDTH-1:0]         hc_i_id_addr_rs2;
  logic                      hc_o_stall_if;
  logic                      hc_o_stall_id;
  logic                      hc_o_stall_ex;
  logic                      hc_o_flush_id;
  logic                      hc_o_flush_ex;
  logic [HC_STATE_WIDTH-1:0] hc_o_state;
  logic                      hc_o_timeout;
  logic [CNT_WIDTH-1:0]      hc_o_stall_cnt;

  modport master (
    output hc_i_change_pc, hc_i_mem_req, hc_i_mem_ack, hc_i_ex_ce, hc_i_ex_is_load,
           hc_i_ex_addr_rd, hc_i_id_ce, hc_i_id_addr_rs1, hc_i_id_addr_rs2,
    input  hc_o_stall_if, hc_o_stall_id, hc_o_stall_ex, hc_o_flush_id, hc_o_flush_ex,
           hc_o_state, hc_o_timeout, hc_o_stall_cnt
  );

  modport slave (
    input  hc_i_change_pc, hc_i_mem_req, hc_i_mem_ack, hc_i_ex_ce, hc_i_ex_is_load,
           hc_i_ex_addr_rd, hc_i_id_ce, hc_i_id_addr_rs1, hc_i_id_addr_rs2,
    output hc_o_stall_if, hc_o_stall_id, hc_o_stall_ex, hc_o_flush_id, hc_o_flush_ex,
           hc_o_state, hc_o_timeout, hc_o_stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             hc_clk,
  input  logic             hc_rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge hc_clk or negedge hc_rst) begin
    if (!hc_rst) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble sequencer around the execute stage.
//   state     | meaning
//   IDLE      | no hazard, pipeline flows
//   FLUSH     | redirect taken, kill decode+execute for FLUSH_CYCLES
//   MEM_WAIT  | load/store outstanding, freeze whole front end
//   LOAD_USE  | one-cycle bubble for a dependent instruction after a load
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_WIDTH    = 16
) (
  input logic           hc_clk,
  input logic           hc_rst,
  hazard_ctrl_if.slave  hc_bus
);

  localparam int FLUSH_W = hc_cnt_width(FLUSH_CYCLES - 1);
  localparam int WAIT_W  = hc_cnt_width(MEM_TIMEOUT - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  logic [HC_STATE_WIDTH-1:0] state;
  logic [FLUSH_W-1:0]        flush_cnt;
  logic [WAIT_W-1:0]         wait_cnt;
  logic                      timeout;
  logic                      load_use;
  logic                      mem_stall;
  logic                      stall_if;
  logic                      stall_id;
  logic                      stall_ex;
  logic                      flush_id;
  logic                      flush_ex;

  always_comb begin
    load_use = hc_bus.hc_i_ex_ce && hc_bus.hc_i_ex_is_load && hc_bus.hc_i_id_ce &&
               (hc_bus.hc_i_ex_addr_rd != '0) &&
               ((hc_bus.hc_i_ex_addr_rd == hc_bus.hc_i_id_addr_rs1) ||
                (hc_bus.hc_i_ex_addr_rd == hc_bus.hc_i_id_addr_rs2));
    mem_stall = hc_bus.hc_i_mem_req && !hc_bus.hc_i_mem_ack;
  end

  always_ff @(posedge hc_clk or negedge hc_rst) begin
    if (!hc_rst) begin
      state     <= HC_IDLE;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        HC_IDLE: begin
          if (hc_bus.hc_i_change_pc) begin
            state     <= HC_FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end else if (mem_stall) begin
            state    <= HC_MEM_WAIT;
            wait_cnt <= '0;
          end else if (load_use) begin
            state <= HC_LOAD_USE;
          end
        end
        HC_FLUSH: begin
          if (hc_bus.hc_i_change_pc) begin
            flush_cnt <= FLUSH_LOAD;
          end else if (flush_cnt == '0) begin
            state <= HC_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        HC_MEM_WAIT: begin
          // Execute is frozen here, so a redirect cannot originate from it.
          if (hc_bus.hc_i_mem_ack) begin
            state <= HC_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= HC_IDLE;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HC_LOAD_USE: begin
          if (hc_bus.hc_i_change_pc) begin
            state     <= HC_FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end else begin
            state <= HC_IDLE;
          end
        end
        default: state <= HC_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    case (state)
      HC_FLUSH: begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end
      HC_MEM_WAIT: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end
      HC_LOAD_USE: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
      default: ;
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .hc_clk (hc_clk),
    .hc_rst (hc_rst),
    .en     (stall_if),
    .count  (hc_bus.hc_o_stall_cnt)
  );

  assign hc_bus.hc_o_stall_if = stall_if;
  assign hc_bus.hc_o_stall_id = stall_id;
  assign hc_bus.hc_o_stall_ex = stall_ex;
  assign hc_bus.hc_o_flush_id = flush_id;
  assign hc_bus.hc_o_flush_ex = flush_ex;
  assign hc_bus.hc_o_state    = state;
  assign hc_bus.hc_o_timeout  = timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic hc_clk;
  logic hc_rst;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if #(.AWIDTH(5), .CNT_WIDTH(16)) bus ();

  hazard_ctrl #(
    .AWIDTH(5), .FLUSH_CYCLES(2), .MEM_TIMEOUT(16), .CNT_WIDTH(16)
  ) dut (
    .hc_clk (hc_clk),
    .hc_rst (hc_rst),
    .hc_bus (bus)
  );

  // {stall_if, stall_id, stall_ex, flush_id, flush_ex, timeout}
  logic [5:0] ctl;
  assign ctl = {bus.hc_o_stall_if, bus.hc_o_stall_id, bus.hc_o_stall_ex,
                bus.hc_o_flush_id, bus.hc_o_flush_ex, bus.hc_o_timeout};

  initial begin
    hc_clk = 1'b0;
    forever #5 hc_clk = ~hc_clk;
  end

  task automatic drive_idle();
    bus.hc_i_change_pc   = 1'b0;
    bus.hc_i_mem_req     = 1'b0;
    bus.hc_i_mem_ack     = 1'b0;
    bus.hc_i_ex_ce       = 1'b0;
    bus.hc_i_ex_is_load  = 1'b0;
    bus.hc_i_ex_addr_rd  = '0;
    bus.hc_i_id_ce       = 1'b0;
    bus.hc_i_id_addr_rs1 = '0;
    bus.hc_i_id_addr_rs2 = '0;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.hc_i_ex_ce       = 1'b1;
    bus.hc_i_ex_is_load  = 1'b1;
    bus.hc_i_ex_addr_rd  = rd;
    bus.hc_i_id_ce       = 1'b1;
    bus.hc_i_id_addr_rs1 = rs1;
    bus.hc_i_id_addr_rs2 = rs2;
  endtask

  task automatic test_reset();
    hc_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.hc_i_change_pc   = 1'($urandom);
      bus.hc_i_mem_req     = 1'($urandom);
      bus.hc_i_mem_ack     = 1'($urandom);
      bus.hc_i_ex_ce       = 1'($urandom);
      bus.hc_i_ex_is_load  = 1'($urandom);
      bus.hc_i_ex_addr_rd  = 5'($urandom);
      bus.hc_i_id_ce       = 1'($urandom);
      bus.hc_i_id_addr_rs1 = 5'($urandom);
      bus.hc_i_id_addr_rs2 = 5'($urandom);
      @(negedge hc_clk);
      n_checks++;
      if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd0) begin
        $display("FAIL reset_hold[%0d]: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=0",
                 i, ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
        n_fail++;
      end
    end
    drive_idle();
    hc_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hc_clk);
      n_checks++;
      if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd0) begin
        $display("FAIL reset_idle[%0d]: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=0",
                 i, ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
        n_fail++;
      end
    end
  endtask

  task automatic test_redirect();
    logic [5:0] exp_single [3];
    logic [5:0] exp_double [4];
    exp_single = '{6'b000110, 6'b000110, 6'b000000};
    exp_double = '{6'b000110, 6'b000110, 6'b000110, 6'b000000};
    bus.hc_i_change_pc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hc_clk);
      bus.hc_i_change_pc = 1'b0;
      n_checks++;
      if (ctl !== exp_single[i] || bus.hc_o_state !== (i < 2 ? 2'd1 : 2'd0)) begin
        $display("FAIL redirect_single[%0d]: ctl=%b state=%0d, want ctl=%b", i, ctl,
                 bus.hc_o_state, exp_single[i]);
        n_fail++;
      end
    end
    bus.hc_i_change_pc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge hc_clk);
      bus.hc_i_change_pc = (i == 0);
      n_checks++;
      if (ctl !== exp_double[i] || bus.hc_o_state !== (i < 3 ? 2'd1 : 2'd0)) begin
        $display("FAIL redirect_double[%0d]: ctl=%b state=%0d, want ctl=%b", i, ctl,
                 bus.hc_o_state, exp_double[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_mem_wait();
    bus.hc_i_mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hc_clk);
      bus.hc_i_mem_req = 1'b0;
      bus.hc_i_mem_ack = (i == 2);
      n_checks++;
      if (ctl !== 6'b111000 || bus.hc_o_state !== 2'd2) begin
        $display("FAIL mem_wait_stall[%0d]: ctl=%b state=%0d, want ctl=111000 state=2",
                 i, ctl, bus.hc_o_state);
        n_fail++;
      end
    end
    @(negedge hc_clk);
    bus.hc_i_mem_ack = 1'b0;
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd3) begin
      $display("FAIL mem_wait_release: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=3",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
    bus.hc_i_mem_req = 1'b1;
    bus.hc_i_mem_ack = 1'b1;
    @(negedge hc_clk);
    drive_idle();
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd3) begin
      $display("FAIL mem_zero_wait: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=3",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    bus.hc_i_mem_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge hc_clk);
      bus.hc_i_mem_req = 1'b0;
      n_checks++;
      if (ctl !== 6'b111000 || bus.hc_o_state !== 2'd2) begin
        $display("FAIL timeout_stall[%0d]: ctl=%b state=%0d, want ctl=111000 state=2",
                 i, ctl, bus.hc_o_state);
        n_fail++;
      end
    end
    @(negedge hc_clk);
    n_checks++;
    if (ctl !== 6'b000001 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd19) begin
      $display("FAIL timeout_pulse: ctl=%b state=%0d cnt=%0d, want ctl=000001 state=0 cnt=19",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
    @(negedge hc_clk);
    n_checks++;
    if (ctl !== 6'b0) begin
      $display("FAIL timeout_single: ctl=%b, want ctl=000000", ctl);
      n_fail++;
    end
  endtask

  task automatic test_ack_at_timeout();
    bus.hc_i_mem_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge hc_clk);
      bus.hc_i_mem_req   = 1'b0;
      bus.hc_i_change_pc = (i == 3);
      bus.hc_i_mem_ack   = (i == 15);
      n_checks++;
      if (ctl !== 6'b111000 || bus.hc_o_state !== 2'd2) begin
        $display("FAIL ack_timeout_stall[%0d]: ctl=%b state=%0d, want ctl=111000 state=2",
                 i, ctl, bus.hc_o_state);
        n_fail++;
      end
    end
    @(negedge hc_clk);
    bus.hc_i_mem_ack = 1'b0;
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd38) begin
      $display("FAIL ack_wins: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=38",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_load_use();
    drive_load(5'd5, 5'd3, 5'd5);
    @(negedge hc_clk);
    drive_idle();
    n_checks++;
    if (ctl !== 6'b110010 || bus.hc_o_state !== 2'd3) begin
      $display("FAIL load_use_rs2: ctl=%b state=%0d, want ctl=110010 state=3", ctl, bus.hc_o_state);
      n_fail++;
    end
    @(negedge hc_clk);
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd20) begin
      $display("FAIL load_use_once: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=20",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
    drive_load(5'd7, 5'd7, 5'd1);
    @(negedge hc_clk);
    drive_idle();
    n_checks++;
    if (ctl !== 6'b110010 || bus.hc_o_state !== 2'd3) begin
      $display("FAIL load_use_rs1: ctl=%b state=%0d, want ctl=110010 state=3", ctl, bus.hc_o_state);
      n_fail++;
    end
    @(negedge hc_clk);
    drive_load(5'd0, 5'd0, 5'd0);
    @(negedge hc_clk);
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0) begin
      $display("FAIL load_use_rd0: ctl=%b state=%0d, want ctl=000000 state=0", ctl, bus.hc_o_state);
      n_fail++;
    end
    drive_load(5'd5, 5'd4, 5'd6);
    @(negedge hc_clk);
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0) begin
      $display("FAIL load_use_mismatch: ctl=%b state=%0d, want ctl=000000 state=0", ctl, bus.hc_o_state);
      n_fail++;
    end
    drive_load(5'd9, 5'd9, 5'd9);
    bus.hc_i_ex_is_load = 1'b0;
    @(negedge hc_clk);
    drive_idle();
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd21) begin
      $display("FAIL load_use_not_load: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=21",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_priority();
    drive_load(5'd5, 5'd5, 5'd5);
    bus.hc_i_change_pc = 1'b1;
    bus.hc_i_mem_req   = 1'b1;
    @(negedge hc_clk);
    drive_idle();
    n_checks++;
    if (ctl !== 6'b000110 || bus.hc_o_state !== 2'd1) begin
      $display("FAIL priority_flush: ctl=%b state=%0d, want ctl=000110 state=1", ctl, bus.hc_o_state);
      n_fail++;
    end
    repeat (2) @(negedge hc_clk);
    drive_load(5'd2, 5'd2, 5'd0);
    bus.hc_i_mem_req = 1'b1;
    bus.hc_i_mem_ack = 1'b1;
    @(negedge hc_clk);
    drive_idle();
    bus.hc_i_change_pc = 1'b1;
    n_checks++;
    if (ctl !== 6'b110010 || bus.hc_o_state !== 2'd3) begin
      $display("FAIL priority_ack_load_use: ctl=%b state=%0d, want ctl=110010 state=3",
               ctl, bus.hc_o_state);
      n_fail++;
    end
    @(negedge hc_clk);
    bus.hc_i_change_pc = 1'b0;
    n_checks++;
    if (ctl !== 6'b000110 || bus.hc_o_state !== 2'd1 || bus.hc_o_stall_cnt !== 16'd22) begin
      $display("FAIL load_use_to_flush: ctl=%b state=%0d cnt=%0d, want ctl=000110 state=1 cnt=22",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
    repeat (2) @(negedge hc_clk);
  endtask

  task automatic test_reset_mid_op();
    bus.hc_i_mem_req = 1'b1;
    @(negedge hc_clk);
    bus.hc_i_mem_req = 1'b0;
    @(negedge hc_clk);
    n_checks++;
    if (bus.hc_o_state !== 2'd2) begin
      $display("FAIL mid_op_setup: state=%0d, want 2", bus.hc_o_state);
      n_fail++;
    end
    #2 hc_rst = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd0) begin
      $display("FAIL mid_op_async_reset: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=0",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
    @(negedge hc_clk);
    hc_rst = 1'b1;
    @(negedge hc_clk);
    n_checks++;
    if (ctl !== 6'b0 || bus.hc_o_state !== 2'd0 || bus.hc_o_stall_cnt !== 16'd0) begin
      $display("FAIL mid_op_after_release: ctl=%b state=%0d cnt=%0d, want ctl=000000 state=0 cnt=0",
               ctl, bus.hc_o_state, bus.hc_o_stall_cnt);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    hc_rst   = 1'b0;
    drive_idle();
    test_reset();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_load_use();
    test_priority();
    test_ack_at_timeout();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencer for the fetch/decode/execute stages: generates stall, flush and bubble controls around the execute stage. Handles taken-branch/jump redirects (multi-cycle flush), load/store memory waits (ack handshake with timeout) and load-use hazards (single bubble). Sits beside the execute stage; its outputs drive the stall/flush inputs of fetch, decode and execute.

Parameters:
AWIDTH, 5, register address width
FLUSH_CYCLES, 2, cycles flush is held after a redirect (>=1)
MEM_TIMEOUT, 16, max cycles waiting for memory ack before forced release (>=2)
CNT_WIDTH, 16, width of stall-cycle performance counter

Ports:
hc_clk  in  1  clock
hc_rst  in  1  asynchronous active-low reset
hc_i_change_pc  in  1  execute redirected PC (taken branch/jal/jalr)
hc_i_mem_req  in  1  execute issued load/store this cycle
hc_i_mem_ack  in  1  memory stage completed access
hc_i_ex_ce  in  1  execute stage holds a valid instruction
hc_i_ex_is_load  in  1  instruction in execute is a load
hc_i_ex_addr_rd  in  AWIDTH  destination register in execute
hc_i_id_ce  in  1  decode stage holds a valid instruction
hc_i_id_addr_rs1  in  AWIDTH  decode source 1
hc_i_id_addr_rs2  in  AWIDTH  decode source 2
hc_o_stall_if  out  1  hold fetch
hc_o_stall_id  out  1  hold decode
hc_o_stall_ex  out  1  hold execute
hc_o_flush_id  out  1  kill decode contents
hc_o_flush_ex  out  1  kill execute contents / insert bubble
hc_o_state  out  2  current FSM state (debug)
hc_o_timeout  out  1  one-cycle pulse on memory-wait timeout
hc_o_stall_cnt  out  CNT_WIDTH  saturating count of cycles with hc_o_stall_if=1

Behaviour:
- Reset (hc_rst=0, async): state=IDLE, wait/flush counters=0, hc_o_stall_cnt=0, hc_o_timeout=0; all stall/flush outputs 0. Reset mid-operation abandons any flush/wait immediately.
- Clock and reset ports are hc_clk and hc_rst; reset is asynchronous and active-low.
- States: IDLE=0, FLUSH=1, MEM_WAIT=2, LOAD_USE=3. Stall/flush outputs are Moore (decode of state only): event sampled at edge N is visible after edge N.
- load_use = hc_i_ex_ce & hc_i_ex_is_load & hc_i_id_ce & (ex_addr_rd!=0) & (ex_addr_rd==rs1 | ex_addr_rd==rs2).
- IDLE outputs all 0. Transition priority: change_pc -> FLUSH (counter=FLUSH_CYCLES-1); else mem_req & !mem_ack -> MEM_WAIT (wait counter=0); else load_use -> LOAD_USE; else stay. mem_req & mem_ack same cycle = zero-wait, stay IDLE (unless load_use).
- FLUSH: flush_id=flush_ex=1, stalls 0. Counter decrements each cycle; at 0 -> IDLE. change_pc while in FLUSH reloads counter to FLUSH_CYCLES-1 (stay). mem_req/load_use ignored (flushed).
- MEM_WAIT: stall_if=stall_id=stall_ex=1, flushes 0. Wait counter increments. mem_ack -> IDLE. counter==MEM_TIMEOUT-1 without ack -> IDLE, hc_o_timeout=1 for exactly the next cycle. change_pc ignored (execute is frozen). ack and timeout same cycle -> ack wins, no pulse.
- LOAD_USE: stall_if=stall_id=1, flush_ex=1, stall_ex=0; lasts exactly one cycle. Next: change_pc -> FLUSH, else -> IDLE (a second load-use cannot recur: bubble cleared execute).
- hc_o_timeout is registered, 0 in all other cycles.
- hc_o_stall_cnt increments by 1 each cycle hc_o_stall_if=1, saturates at all-ones, never wraps.
- Counters sized $clog2 of their max value, minimum 1 bit.

Decomposition:
- Shared header: state encodings (HC_IDLE..HC_LOAD_USE), HC_STATE_WIDTH=2.
- Sub-module sat_counter (saturating up-counter, enable, async active-low reset) for hc_o_stall_cnt; FSM and wait/flush counters stay in hazard_ctrl.

Test Plan:
- Reset: hold hc_rst=0 with random inputs -> all outputs 0, state=0; release, idle inputs -> stays IDLE, stall_cnt=0.
- Redirect: pulse change_pc at edge N -> flush_id=flush_ex=1 for 2 cycles after N, then 0; second pulse at N+1 -> flush extends to N+3.
- Memory wait: mem_req at edge N, mem_ack at N+3 -> all three stalls high cycles N+1..N+3, IDLE after; stall_cnt=3. mem_req+mem_ack same cycle -> no stall.
- Timeout: mem_req, ack never -> stalls held 16 cycles, timeout pulse 1 cycle, returns IDLE; stall_cnt=16.
- Load-use: ex load rd=5, id rs2=5, both ce -> one cycle stall_if=stall_id=flush_ex=1; rd=0 or rs mismatch -> no stall.
- Priority/reset mid-op: change_pc+mem_req+load_use together -> FLUSH; assert reset during MEM_WAIT -> outputs 0 asynchronously, stall_cnt cleared.
